// File: rtl/pdp11_iopage_pkg.sv
// Shared constants and types for the PDP-11 I/O-page bridge: page base,
// bridge state encoding and well-known device offsets.
package pdp11_iopage_pkg;

  localparam logic [8:0]  IOPAGE_BASE = 9'o777;

  localparam logic [12:0] OFF_BOOTROM = 13'o13000;
  localparam logic [12:0] OFF_TTY     = 13'o17560;
  localparam logic [12:0] OFF_RK      = 13'o17400;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic logic is_iopage(input logic [21:0] addr);
    return addr[21:13] == IOPAGE_BASE;
  endfunction

endpackage

// File: rtl/iopage_bridge_if.sv
// CPU-side request port of the I/O-page bridge.
//
// Handshake: the master raises bus_req with address/control/data stable and
// holds it until it sees a one-cycle bus_ack or bus_nxm pulse; bus_data_out is
// valid in the bus_ack cycle. The master must drop bus_req before a new cycle
// can start; a request that stays high after completion is not re-served.
interface iopage_bridge_if;
  logic [21:0] bus_addr;
  logic        bus_req;
  logic        bus_wr;
  logic        bus_byte_op;
  logic [15:0] bus_data_in;
  logic [15:0] bus_data_out;
  logic        bus_ack;
  logic        bus_nxm;

  modport master (
    output bus_addr, bus_req, bus_wr, bus_byte_op, bus_data_in,
    input  bus_data_out, bus_ack, bus_nxm
  );

  modport slave (
    input  bus_addr, bus_req, bus_wr, bus_byte_op, bus_data_in,
    output bus_data_out, bus_ack, bus_nxm
  );
endinterface

// File: rtl/iopage_select.sv
// Priority select over the device decode lines: the lowest-index asserting
// slot wins; multi_hit flags more than one decode at once.
module iopage_select #(
  parameter int NDEV = 4
) (
  input  logic [NDEV-1:0]    dev_decode,
  input  logic [16*NDEV-1:0] dev_data,
  output logic               sel_valid,
  output logic [15:0]        sel_data,
  output logic               multi_hit
);

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    // Scan downward so the lowest index is the last (winning) assignment.
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (dev_decode[i]) begin
        sel_valid = 1'b1;
        sel_data  = dev_data[16*i +: 16];
      end
    end
    multi_hit = |(dev_decode & (dev_decode - NDEV'(1)));
  end

endmodule

// File: rtl/iopage_bridge.sv
// Bridge from the CPU request port to the I/O-page device strobes.
// Build option: IOPAGE_NXM_EN enables the no-decode timeout and bus_nxm abort.
module iopage_bridge
  import pdp11_iopage_pkg::*;
#(
  parameter int NDEV          = 4,
  parameter int ACCESS_CYCLES = 2,
  parameter int TIMEOUT       = 16
) (
  input  logic               clk,
  input  logic               reset,
  iopage_bridge_if.slave     bus,
  output logic [12:0]        iopage_addr,
  output logic               iopage_rd,
  output logic               iopage_wr,
  output logic               iopage_byte_op,
  output logic [15:0]        data_in,
  input  logic [NDEV-1:0]    dev_decode,
  input  logic [16*NDEV-1:0] dev_data,
  output logic               conflict,
  output state_t             state_dbg
);

  localparam int CNT_MAX = (TIMEOUT > ACCESS_CYCLES) ? TIMEOUT : ACCESS_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CAP_CNT = CW'(ACCESS_CYCLES - 1);
`ifdef IOPAGE_NXM_EN
  localparam logic [CW-1:0] TO_CNT  = CW'(TIMEOUT - 1);
`endif

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [12:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        byte_q, byte_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        nxm_q, nxm_d;
  logic        conflict_q, conflict_d;

  logic        sel_valid;
  logic [15:0] sel_data;
  logic        multi_hit;
  logic        start;
  logic        capture;
  logic        timeout;

  iopage_select #(.NDEV(NDEV)) u_select (
    .dev_decode (dev_decode),
    .dev_data   (dev_data),
    .sel_valid  (sel_valid),
    .sel_data   (sel_data),
    .multi_hit  (multi_hit)
  );

  always_comb begin
    start = (state_q == ST_IDLE) && bus.bus_req && is_iopage(bus.bus_addr);
`ifdef IOPAGE_NXM_EN
    capture = (state_q == ST_ACCESS) && sel_valid && (cnt_q >= CAP_CNT);
    timeout = (state_q == ST_ACCESS) && !sel_valid && (cnt_q >= TO_CNT);
`else
    // Without a timeout an undecoded access completes as a floating-bus zero.
    capture = (state_q == ST_ACCESS) && (cnt_q >= CAP_CNT);
    timeout = 1'b0;
`endif
  end

  // Next-state process.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_ACCESS;
      ST_ACCESS:  if (capture || timeout) state_d = ST_RELEASE;
      ST_RELEASE: if (!bus.bus_req) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    addr_d     = addr_q;
    wr_d       = wr_q;
    byte_d     = byte_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = '0;
    ack_d      = capture;
    nxm_d      = timeout;
    conflict_d = conflict_q | (capture && multi_hit);
    if (start) begin
      addr_d  = bus.bus_addr[12:0];
      wr_d    = bus.bus_wr;
      byte_d  = bus.bus_byte_op;
      wdata_d = bus.bus_data_in;
    end
    if (state_q == ST_ACCESS && !capture && !timeout) cnt_d = cnt_q + CW'(1);
    if (capture) rdata_d = (!wr_q && sel_valid) ? sel_data : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      byte_q     <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      nxm_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      byte_q     <= byte_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      nxm_q      <= nxm_d;
      conflict_q <= conflict_d;
    end
  end

  // Output process: strobes follow the state so they drop on the same edge.
  always_comb begin
    iopage_rd        = (state_q == ST_ACCESS) && !wr_q;
    iopage_wr        = (state_q == ST_ACCESS) && wr_q;
    iopage_byte_op   = (state_q == ST_ACCESS) && byte_q;
    iopage_addr      = addr_q;
    data_in          = wdata_q;
    bus.bus_data_out = rdata_q;
    bus.bus_ack      = ack_q;
    bus.bus_nxm      = nxm_q;
    conflict         = conflict_q;
    state_dbg        = state_q;
  end

endmodule

// File: tb/tb_iopage_bridge.sv
// Directed bench for iopage_bridge: reads, writes, conflicts, ignored
// requests, undecoded accesses and reset in the middle of an access.
module tb_iopage_bridge;
  import pdp11_iopage_pkg::*;

  logic        clk;
  logic        reset;
  logic [12:0] iopage_addr;
  logic        iopage_rd;
  logic        iopage_wr;
  logic        iopage_byte_op;
  logic [15:0] data_in;
  logic [3:0]  dev_decode;
  logic [63:0] dev_data;
  logic        conflict;
  state_t      state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  int          obs_ack_cyc, obs_nxm_cyc, obs_ack_cnt, obs_nxm_cnt;
  int          obs_rd_cnt, obs_wr_cnt, obs_byte_cnt;
  logic [12:0] obs_addr;
  logic [15:0] obs_wdata;
  logic [15:0] obs_ack_data;

  iopage_bridge_if bus ();

  iopage_bridge #(.NDEV(4), .ACCESS_CYCLES(2), .TIMEOUT(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .iopage_addr    (iopage_addr),
    .iopage_rd      (iopage_rd),
    .iopage_wr      (iopage_wr),
    .iopage_byte_op (iopage_byte_op),
    .data_in        (data_in),
    .dev_decode     (dev_decode),
    .dev_data       (dev_data),
    .conflict       (conflict),
    .state_dbg      (state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: hold a request for n_cyc clocks, then drop it for 3 more clocks,
  // recording every strobe/ack/nxm sample; cycle 1 is the one after the
  // request edge.
  task automatic run_req(input logic [21:0] addr, input logic wr,
                         input logic byte_op, input logic [15:0] wdata,
                         input int n_cyc);
    obs_ack_cyc = 0; obs_nxm_cyc = 0; obs_ack_cnt = 0; obs_nxm_cnt = 0;
    obs_rd_cnt = 0; obs_wr_cnt = 0; obs_byte_cnt = 0;
    obs_addr = '0; obs_wdata = '0; obs_ack_data = '0;
    bus.bus_addr    = addr;
    bus.bus_wr      = wr;
    bus.bus_byte_op = byte_op;
    bus.bus_data_in = wdata;
    bus.bus_req     = 1'b1;
    for (int c = 1; c <= n_cyc + 3; c++) begin
      @(posedge clk);
      #1;
      if (c == n_cyc + 1) bus.bus_req = 1'b0;
      if (iopage_rd) obs_rd_cnt++;
      if (iopage_wr) obs_wr_cnt++;
      if (iopage_byte_op) obs_byte_cnt++;
      if (iopage_rd || iopage_wr) begin
        obs_addr  = iopage_addr;
        obs_wdata = data_in;
      end
      if (bus.bus_ack) begin
        obs_ack_cnt++;
        obs_ack_data = bus.bus_data_out;
        if (obs_ack_cyc == 0) obs_ack_cyc = c;
      end
      if (bus.bus_nxm) begin
        obs_nxm_cnt++;
        if (obs_nxm_cyc == 0) obs_nxm_cyc = c;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (state_dbg !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
    end
    n_checks++;
    if ({iopage_rd, iopage_wr, iopage_byte_op, bus.bus_ack, bus.bus_nxm, conflict} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 000000",
        {iopage_rd, iopage_wr, iopage_byte_op, bus.bus_ack, bus.bus_nxm, conflict});
    end
    n_checks++;
    if ({iopage_addr, data_in, bus.bus_data_out} !== 45'b0) begin
      n_fail++; $display("FAIL reset_data: addr %0o data_in %0o data_out %0o expected 0",
        iopage_addr, data_in, bus.bus_data_out);
    end
  endtask

  task automatic test_word_read();
    dev_decode = 4'b0001;
    dev_data   = {48'h0, 16'o012706};
    run_req(22'o17773000, 1'b0, 1'b0, 16'h0, 6);
    n_checks++;
    if (obs_ack_cyc !== 3 || obs_ack_cnt !== 1) begin
      n_fail++; $display("FAIL read_ack: cycle %0d count %0d expected cycle 3 count 1", obs_ack_cyc, obs_ack_cnt);
    end
    n_checks++;
    if (obs_ack_data !== 16'o012706) begin
      n_fail++; $display("FAIL read_data: got %0o expected 12706", obs_ack_data);
    end
    n_checks++;
    if (obs_rd_cnt !== 2 || obs_wr_cnt !== 0) begin
      n_fail++; $display("FAIL read_strobe: rd %0d wr %0d expected 2 0", obs_rd_cnt, obs_wr_cnt);
    end
    n_checks++;
    if (obs_addr !== OFF_BOOTROM) begin
      n_fail++; $display("FAIL read_addr: got %0o expected 13000", obs_addr);
    end
  endtask

  task automatic test_no_device();
    dev_decode = 4'b0000;
    dev_data   = {4{16'o177777}};
    run_req(22'o17770000, 1'b0, 1'b0, 16'h0, 22);
`ifdef IOPAGE_NXM_EN
    n_checks++;
    if (obs_nxm_cyc !== 17 || obs_nxm_cnt !== 1 || obs_ack_cnt !== 0) begin
      n_fail++; $display("FAIL nxm_timing: nxm cycle %0d nxm %0d ack %0d expected 17 1 0",
        obs_nxm_cyc, obs_nxm_cnt, obs_ack_cnt);
    end
    n_checks++;
    if (bus.bus_data_out !== 16'o012706) begin
      n_fail++; $display("FAIL nxm_data_hold: got %0o expected 12706", bus.bus_data_out);
    end
`else
    n_checks++;
    if (obs_ack_cyc !== 3 || obs_ack_cnt !== 1 || obs_nxm_cnt !== 0) begin
      n_fail++; $display("FAIL float_ack: cycle %0d ack %0d nxm %0d expected 3 1 0",
        obs_ack_cyc, obs_ack_cnt, obs_nxm_cnt);
    end
    n_checks++;
    if (obs_ack_data !== 16'h0000) begin
      n_fail++; $display("FAIL float_data: got %0o expected 0", obs_ack_data);
    end
`endif
  endtask

  task automatic test_byte_write_held_req();
    dev_decode = 4'b0010;
    dev_data   = {32'h0, 16'o055555, 16'h0};
    run_req(22'o17777566, 1'b1, 1'b1, 16'o000101, 20);
    n_checks++;
    if (obs_wr_cnt !== 2 || obs_rd_cnt !== 0 || obs_byte_cnt !== 2) begin
      n_fail++; $display("FAIL write_strobe: wr %0d rd %0d byte %0d expected 2 0 2",
        obs_wr_cnt, obs_rd_cnt, obs_byte_cnt);
    end
    n_checks++;
    if (obs_wdata !== 16'o000101 || obs_addr !== 13'o17566) begin
      n_fail++; $display("FAIL write_data: data %0o addr %0o expected 101 17566", obs_wdata, obs_addr);
    end
    n_checks++;
    if (obs_ack_cyc !== 3 || obs_ack_cnt !== 1) begin
      n_fail++; $display("FAIL write_held_req: ack cycle %0d count %0d expected 3 1", obs_ack_cyc, obs_ack_cnt);
    end
    n_checks++;
    if (bus.bus_data_out !== 16'h0000) begin
      n_fail++; $display("FAIL write_data_out: got %0o expected 0", bus.bus_data_out);
    end
    n_checks++;
    if (state_dbg !== ST_IDLE) begin
      n_fail++; $display("FAIL write_release: state %0d expected %0d", state_dbg, ST_IDLE);
    end
  endtask

  task automatic test_conflict();
    dev_decode = 4'b0101;
    dev_data   = {16'h0, 16'o000222, 16'o000333, 16'o000111};
    run_req(22'o17777400, 1'b0, 1'b0, 16'h0, 6);
    n_checks++;
    if (obs_ack_data !== 16'o000111) begin
      n_fail++; $display("FAIL conflict_data: got %0o expected 111", obs_ack_data);
    end
    n_checks++;
    if (conflict !== 1'b1) begin
      n_fail++; $display("FAIL conflict_set: got %b expected 1", conflict);
    end
    dev_decode = 4'b0010;
    run_req(22'o17777560, 1'b0, 1'b0, 16'h0, 6);
    n_checks++;
    if (obs_ack_data !== 16'o000333 || conflict !== 1'b1) begin
      n_fail++; $display("FAIL conflict_sticky: data %0o conflict %b expected 333 1", obs_ack_data, conflict);
    end
  endtask

  task automatic test_non_iopage();
    dev_decode = 4'b0001;
    dev_data   = {48'h0, 16'o012345};
    run_req(22'o00001000, 1'b0, 1'b0, 16'h0, 8);
    n_checks++;
    if (obs_rd_cnt !== 0 || obs_wr_cnt !== 0 || obs_ack_cnt !== 0 || obs_nxm_cnt !== 0) begin
      n_fail++; $display("FAIL non_iopage: rd %0d wr %0d ack %0d nxm %0d expected all 0",
        obs_rd_cnt, obs_wr_cnt, obs_ack_cnt, obs_nxm_cnt);
    end
    n_checks++;
    if (state_dbg !== ST_IDLE) begin
      n_fail++; $display("FAIL non_iopage_state: got %0d expected %0d", state_dbg, ST_IDLE);
    end
  endtask

  task automatic test_reset_mid_access();
    dev_decode = 4'b0001;
    dev_data   = {48'h0, 16'o054321};
    bus.bus_addr = 22'o17773002; bus.bus_wr = 1'b0; bus.bus_byte_op = 1'b0;
    bus.bus_req  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (iopage_rd !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: rd %b expected 1", iopage_rd);
    end
    reset = 1'b0;
    bus.bus_req = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({iopage_rd, iopage_wr, bus.bus_ack, bus.bus_nxm} !== 4'b0 || state_dbg !== ST_IDLE) begin
      n_fail++; $display("FAIL midrst_strobes: rd %b wr %b ack %b nxm %b state %0d expected 0 0 0 0 0",
        iopage_rd, iopage_wr, bus.bus_ack, bus.bus_nxm, state_dbg);
    end
    n_checks++;
    if (conflict !== 1'b0 || bus.bus_data_out !== 16'h0) begin
      n_fail++; $display("FAIL midrst_clear: conflict %b data_out %0o expected 0 0", conflict, bus.bus_data_out);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.bus_ack !== 1'b0 || bus.bus_nxm !== 1'b0) begin
      n_fail++; $display("FAIL midrst_no_ack: ack %b nxm %b expected 0 0", bus.bus_ack, bus.bus_nxm);
    end
    run_req(22'o17773002, 1'b0, 1'b0, 16'h0, 6);
    n_checks++;
    if (obs_ack_cyc !== 3 || obs_ack_data !== 16'o054321 || obs_rd_cnt !== 2) begin
      n_fail++; $display("FAIL midrst_fresh: ack cycle %0d data %0o rd %0d expected 3 54321 2",
        obs_ack_cyc, obs_ack_data, obs_rd_cnt);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.bus_addr = '0; bus.bus_req = 1'b0; bus.bus_wr = 1'b0;
    bus.bus_byte_op = 1'b0; bus.bus_data_in = '0;
    dev_decode = '0; dev_data = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    test_word_read();
    test_no_device();
    test_byte_write_held_req();
    test_conflict();
    test_non_iopage();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iopage_bridge.md
Name: iopage_bridge

Overview:
- Sits between the CPU unibus-style request port and the I/O-page slave devices (bootrom, console, rk11, ...).
- Recognises I/O-page addresses 17760000–17777777 and drives the shared iopage_addr, data_in, rd, wr and byte_op strobes.
- Collects each device's decode and data_out, and returns read data with an ack, or a non-existent-memory (NXM) abort.

Parameters:
- NDEV, 4, number of device slots.
- ACCESS_CYCLES, 2, cycles the strobes are held before data is captured (≥1).
- TIMEOUT, 16, cycles without any decode before NXM (≥2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- bus_addr  in  22  physical address from CPU
- bus_req  in  1  request; held until bus_ack or bus_nxm
- bus_wr  in  1  1=write, 0=read
- bus_byte_op  in  1  byte access
- bus_data_in  in  16  write data
- bus_data_out  out  16  read data, valid with bus_ack
- bus_ack  out  1  one-cycle completion pulse
- bus_nxm  out  1  one-cycle abort pulse
- iopage_addr  out  13  offset within I/O page
- iopage_rd  out  1  read strobe to devices
- iopage_wr  out  1  write strobe to devices
- iopage_byte_op  out  1  byte strobe to devices
- data_in  out  16  write data to devices
- dev_decode  in  NDEV  per-device decode
- dev_data  in  16*NDEV  per-device data_out; slot i is bits [16i+15:16i]
- conflict  out  1  sticky: more than one decode seen

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; all outputs 0, including conflict; counters 0.
- IDLE: if bus_req && bus_addr[21:13]==9'o777, latch addr[12:0], wr, byte_op and data in the same edge, then go to ACCESS. Otherwise stay in IDLE; non-I/O-page requests are ignored (the memory controller handles them).
- ACCESS: iopage_rd=!wr or iopage_wr=wr, held for the whole state; iopage_addr, byte_op and data_in are stable from the registers. A counter increments each cycle.
  - Once any dev_decode bit is set and count reaches ACCESS_CYCLES-1: select the lowest-index asserted slot, register its data into bus_data_out (reads only; writes return 0), pulse bus_ack, drop the strobes, and go to RELEASE.
  - If more than one decode bit is set at capture, set conflict (cleared only by reset).
  - If no decode is seen by count==TIMEOUT-1: pulse bus_nxm, drop the strobes, and go to RELEASE.
- RELEASE: wait for bus_req==0, then go to IDLE. A held bus_req never starts a second cycle.
- Latency: request edge to ack is ACCESS_CYCLES+1 clocks (default 3). Request edge to nxm is TIMEOUT+1.
- Byte reads: the device's data is passed unmodified (devices right-justify the addressed byte). Byte writes: data_in=bus_data_in unmodified; lane selection is the device's job via iopage_addr[0].
- bus_data_out holds its value until the next capture.
- Reset during ACCESS: strobes drop at that edge and no ack or nxm is issued.
- bus_req dropped mid-ACCESS: the cycle still completes (ack/nxm is issued), then the block returns through RELEASE.

Optional Feature:
- IOPAGE_NXM_EN defined: timeout/NXM behaviour as above.
- Not defined: no timeout counter and bus_nxm is tied 0. A no-decode cycle completes at count==ACCESS_CYCLES-1 with bus_ack and bus_data_out=0 (floating-bus read as zero, write discarded).

Decomposition:
- Shared package pdp11_iopage_pkg holds:
  - the I/O-page base constant (9'o777 on addr[21:13]);
  - the state encoding (IDLE, ACCESS, RELEASE);
  - device offset constants (bootrom 13'o13000, TTY 13'o17560, RK 13'o17400).
- One sub-module is natural: iopage_select, a combinational priority encoder plus data mux over dev_decode/dev_data that outputs a valid bit, the selected data and a multi-hit flag.

Test Plan:
- Word read 17773000, bootrom in slot 0 returning 16'o012706: bus_ack on cycle 3 with bus_data_out=16'o012706, iopage_rd high for exactly 2 cycles, iopage_addr=13'o13000.
- Byte write 17777566 with data 16'o000101, TTY in slot 1: iopage_wr=1, byte_op=1, data_in=16'o101 for 2 cycles; ack; the held req produces no second cycle until req drops.
- Read 17770000 with no device (NXM_EN defined): bus_nxm at cycle 17, no bus_ack, bus_data_out unchanged. With NXM_EN undefined: ack at cycle 3 with data 0.
- Slots 0 and 2 both decode with data 16'o111/16'o222: bus_data_out=16'o111, conflict=1 and stays 1 until reset.
- Request to 00001000: no strobes, no ack or nxm, state stays IDLE.
- reset=0 asserted in the second ACCESS cycle: strobes are 0 on the next edge, no ack, and a fresh request afterwards completes normally.
